// File: rtl/line_window_buffer_pkg.sv
// Shared constants and types for the line window buffer that feeds the
// 3x3 convolution stage.
package line_window_buffer_pkg;

  localparam int PIX_W    = 16;
  localparam int H_ACTIVE = 320;
  localparam int V_ACTIVE = 240;
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [2:0]     column_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fill_state_t;

endpackage

// File: rtl/line_window_buffer_ram.sv
// One line of pixel storage: independent write and read ports, with a
// registered read that returns the pre-write value on an address collision.
module line_ram
  import line_window_buffer_pkg::*;
#(
  parameter int DEPTH = 320,
  parameter int WIDTH = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_in,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the memory array is deliberately never reset so it maps onto block
  // RAM; the fill state in the parent masks whatever it holds after reset.
  // NOTE: non-blocking assignments give the read-before-write ordering that
  // the row shift relies on.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/line_window_buffer.sv
// Stores the two previous raster lines and emits, per pixel, the vertical
// column {row-2, row-1, row} at the current hcount with a fixed 2-cycle latency.
module line_window_buffer #(
  parameter int H_ACTIVE = line_window_buffer_pkg::H_ACTIVE,
  parameter int V_ACTIVE = line_window_buffer_pkg::V_ACTIVE,
  parameter int PIX_W    = line_window_buffer_pkg::PIX_W
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [PIX_W-1:0]      data_in,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic                  data_valid_in,
  output logic [2:0][PIX_W-1:0] line_out,
  output logic [10:0]           hcount_out,
  output logic [9:0]            vcount_out,
  output logic                  data_valid_out
);

  import line_window_buffer_pkg::*;

  localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [HCOUNT_W-1:0] H_LIM  = HCOUNT_W'(H_ACTIVE);
  localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_ACTIVE - 1);
  localparam logic [VCOUNT_W-1:0] V_LIM  = VCOUNT_W'(V_ACTIVE);

  logic acc;
  logic frame_start;

  assign acc         = data_valid_in && (hcount_in < H_LIM) && (vcount_in < V_LIM);
  assign frame_start = acc && (hcount_in == '0) && (vcount_in == '0);

  logic [PIX_W-1:0]    s1_pix;
  logic [HCOUNT_W-1:0] s1_h;
  logic [VCOUNT_W-1:0] s1_v;
  logic                s1_acc;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_pix <= '0;
      s1_h   <= '0;
      s1_v   <= '0;
      s1_acc <= 1'b0;
    end else begin
      s1_pix <= data_in;
      s1_h   <= hcount_in;
      s1_v   <= vcount_in;
      s1_acc <= acc;
    end
  end

  logic [PIX_W-1:0] la_rd;
  logic [PIX_W-1:0] lb_rd;

  // LA holds row-1; LB receives what LA held, so the rows shift down by one.
  line_ram #(.DEPTH(H_ACTIVE), .WIDTH(PIX_W)) u_line_a (
    .clk_in  (clk_in),
    .rd_en   (acc),
    .rd_addr (hcount_in[AW-1:0]),
    .rd_data (la_rd),
    .wr_en   (s1_acc),
    .wr_addr (s1_h[AW-1:0]),
    .wr_data (s1_pix)
  );

  line_ram #(.DEPTH(H_ACTIVE), .WIDTH(PIX_W)) u_line_b (
    .clk_in  (clk_in),
    .rd_en   (acc),
    .rd_addr (hcount_in[AW-1:0]),
    .rd_data (lb_rd),
    .wr_en   (s1_acc),
    .wr_addr (s1_h[AW-1:0]),
    .wr_data (la_rd)
  );

  fill_state_t fill_q;
  fill_state_t fill_d;

  // NOTE: fill_d takes its current value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    fill_d = fill_q;
    if (s1_acc && (s1_h == H_LAST)) begin
      case (fill_q)
        EMPTY:   fill_d = ONE;
        ONE:     fill_d = TWO;
        default: fill_d = fill_q;
      endcase
    end
    // A new frame outranks an end-of-line landing in the same cycle.
    if (frame_start) fill_d = EMPTY;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) fill_q <= EMPTY;
    else        fill_q <= fill_d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      line_out       <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      data_valid_out <= 1'b0;
    end else begin
      line_out[0]    <= s1_pix;
      line_out[1]    <= (fill_q != EMPTY) ? la_rd : '0;
      line_out[2]    <= (fill_q == TWO)   ? lb_rd : '0;
      hcount_out     <= s1_h;
      vcount_out     <= s1_v;
      data_valid_out <= s1_acc;
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer with a 4-pixel line; a pixel-level
// reference model fills a scoreboard that is drained two cycles later.
module tb_line_window_buffer;

  localparam int H = 4;
  localparam int V = 240;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic [15:0]      data_in = '0;
  logic [10:0]      hcount_in = '0;
  logic [9:0]       vcount_in = '0;
  logic             data_valid_in = 1'b0;
  logic [2:0][15:0] line_out;
  logic [10:0]      hcount_out;
  logic [9:0]       vcount_out;
  logic             data_valid_out;

  line_window_buffer #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(16)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in        (data_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .data_valid_in  (data_valid_in),
    .line_out       (line_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .data_valid_out (data_valid_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        v;
    logic [47:0] col;
    logic [10:0] h;
    logic [9:0]  vc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mla [H];
  logic [15:0] mlb [H];
  int          mfill;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic prime();
    exp_t z;
    z.v = 1'b0; z.col = '0; z.h = '0; z.vc = '0;
    q.delete();
    q.push_back(z);
    mfill = 0;
  endtask

  // Drive one cycle of input, predict its output, then compare the output
  // that belongs to the previous cycle's input.
  task automatic step(input logic vld, input int h, input int v, input logic [15:0] d);
    exp_t e;
    exp_t o;
    logic [15:0] c1;
    logic [15:0] c2;
    data_valid_in = vld;
    hcount_in     = 11'(h);
    vcount_in     = 10'(v);
    data_in       = d;
    e.v   = vld && (h < H) && (v < V);
    e.h   = 11'(h);
    e.vc  = 10'(v);
    e.col = 'x;
    if (e.v) begin
      if (h == 0 && v == 0) mfill = 0;
      c1 = (mfill >= 1) ? mla[h] : 16'h0;
      c2 = (mfill == 2) ? mlb[h] : 16'h0;
      e.col = {c2, c1, d};
      mlb[h] = mla[h];
      mla[h] = d;
      if (h == H - 1 && mfill < 2) mfill++;
    end
    q.push_back(e);
    @(posedge clk_in);
    #1;
    if (q.size() >= 2) begin
      o = q.pop_front();
      check("valid", 64'(data_valid_out), 64'(o.v));
      check("hcount", 64'(hcount_out), 64'(o.h));
      check("vcount", 64'(vcount_out), 64'(o.vc));
      if (o.v) check("line", 64'(line_out), 64'(o.col));
    end else begin
      total++;
      bad++;
      $error("FAIL scoreboard_underflow observed=%0d expected=2", q.size());
    end
  endtask

  task automatic row(input int v, input int base);
    for (int c = 0; c < H; c++) step(1'b1, c, v, 16'(base + c));
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_line", 64'(line_out), 64'h0);
    check("rst_valid", 64'(data_valid_out), 64'h0);
    check("rst_hcount", 64'(hcount_out), 64'h0);
    check("rst_vcount", 64'(vcount_out), 64'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    prime();

    // Single row 0 with pixels 1..4.
    row(0, 1);
    step(1'b0, 0, 0, 16'h0);
    check("row0_last_col", 64'(line_out), 64'h0000_0000_0004);

    // Fresh frame, value = row*16 + col.
    row(0, 16'h00);
    row(1, 16'h10);
    row(2, 16'h20);
    step(1'b0, 0, 3, 16'h0);
    check("row2_col3", 64'(line_out), {16'h0, 16'h0003, 16'h0013, 16'h0023});

    // Blanking count is not accepted.
    step(1'b1, H + 5, 2, 16'hdead);
    step(1'b0, 0, 3, 16'h0);
    check("blank_hcount", 64'(hcount_out), 64'(H + 5));
    check("blank_valid", 64'(data_valid_out), 64'h0);

    // Valid toggling 1-0-0-1 inside a line.
    step(1'b1, 0, 3, 16'h30);
    step(1'b0, 0, 3, 16'hbeef);
    step(1'b0, 1, 3, 16'hbeef);
    step(1'b1, 1, 3, 16'h31);
    step(1'b1, 2, 3, 16'h32);
    step(1'b1, 3, 3, 16'h33);

    // New frame: stale rows must be masked throughout row 0.
    step(1'b1, 0, 0, 16'h80);
    step(1'b1, 1, 0, 16'h81);
    check("mask_new_frame", 64'({line_out[2], line_out[1]}), 64'h0);
    step(1'b1, 2, 0, 16'h82);
    step(1'b1, 3, 0, 16'h83);
    row(1, 16'h90);
    step(1'b1, 0, 2, 16'ha0);
    step(1'b1, 1, 2, 16'ha1);

    // Asynchronous reset in the middle of row 2.
    #2;
    rst_in = 1'b1;
    data_valid_in = 1'b0;
    #1;
    check("async_line", 64'(line_out), 64'h0);
    check("async_valid", 64'(data_valid_out), 64'h0);
    check("async_hcount", 64'(hcount_out), 64'h0);
    check("async_vcount", 64'(vcount_out), 64'h0);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    prime();

    row(5, 16'hc0);
    row(6, 16'hd0);
    row(7, 16'he0);
    step(1'b0, 0, 8, 16'h0);
    step(1'b0, 0, 8, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Upstream neighbour of the 3x3 convolution stage.
- Takes the raster pixel stream (RGB565, one pixel per valid cycle, with hcount/vcount) and stores the two previous lines.
- Each cycle it emits a vertical 3-pixel column for the current hcount: the current row plus the two rows above it.
- The convolution stage shifts these columns horizontally to build its 3x3 window.

Parameters:
- H_ACTIVE, 320, active pixels per line; line-memory depth.
- V_ACTIVE, 240, active lines per frame; vcount_in >= V_ACTIVE is ignored.
- PIX_W, 16, pixel width (RGB565).

Ports:
- clk_in  in  1  system clock; all logic on posedge.
- rst_in  in  1  asynchronous, active-high reset.
- data_in  in  PIX_W  incoming pixel.
- hcount_in  in  11  column of data_in.
- vcount_in  in  10  row of data_in.
- data_valid_in  in  1  data_in/hcount_in/vcount_in are a real pixel.
- line_out  out  3 x PIX_W (packed [2:0][PIX_W-1:0])  [0]=row vcount, [1]=row vcount-1, [2]=row vcount-2, all at the same column.
- hcount_out  out  11  hcount_in delayed 2 cycles.
- vcount_out  out  10  vcount_in delayed 2 cycles.
- data_valid_out  out  1  qualified valid delayed 2 cycles.

Behaviour:
- Reset (async assert, sync release):
  - line_out=0, hcount_out=0, vcount_out=0, data_valid_out=0.
  - Pipeline valids cleared; fill state -> EMPTY.
  - Line memories are NOT cleared; stale contents are masked by the fill state.
- Accept condition: acc = data_valid_in && hcount_in < H_ACTIVE && vcount_in < V_ACTIVE.
- Line memories:
  - Two memories, LA (row-1) and LB (row-2), each H_ACTIVE x PIX_W, synchronous read with 1-cycle latency.
- Pipeline, fixed latency 2:
  - Stage 1 (cycle N): if acc, read LA[hcount_in] and LB[hcount_in]; register data_in, hcount_in, vcount_in, acc.
  - Stage 2 (cycle N+1): if stage-1 acc, write LA[h] <= stage-1 pixel and LB[h] <= LA read data. This is a read-before-write shift of the rows.
  - Stage 2 also registers the outputs:
    - line_out[0] = stage-1 pixel.
    - line_out[1] = LA read data if fill >= ONE, else 0.
    - line_out[2] = LB read data if fill == TWO, else 0.
- Counts and valid:
  - hcount_out/vcount_out always pipeline their inputs, whether or not the pixel is accepted.
  - data_valid_out = acc delayed 2 cycles.
- Back-to-back pixels use distinct addresses, so there is no read/write hazard.
  - Same-address reads on consecutive cycles cannot occur in a legal raster.
  - If they do, read data is the pre-write value; no forwarding.
- Fill FSM (EMPTY, ONE, TWO):
  - Any state -> EMPTY on an accepted pixel with hcount_in==0 && vcount_in==0. The new frame's first row is treated as the top row.
  - EMPTY -> ONE, and ONE -> TWO, when stage 2 writes a pixel with h == H_ACTIVE-1.
  - TWO holds until the next frame start or reset.
  - The FSM state sampled by stage 2 is the one in effect before that cycle's end-of-line transition.
- Simultaneous events: frame-start with end-of-line in the same cycle -> frame-start wins (state EMPTY).
- Non-accepted cycles (valid low, or blanking counts) write nothing and hold the FSM. Gaps of any length between pixels are allowed.
- Reset mid-line: partial rows are discarded logically; outputs restart masked until two new full lines are written.

Decomposition:
- Shared package:
  - PIX_W, H_ACTIVE, V_ACTIVE, HCOUNT_W=11, VCOUNT_W=10.
  - Typedef pixel_t (logic [15:0]).
  - Typedef column_t (pixel_t [2:0]).
  - Enum fill_state_t {EMPTY, ONE, TWO}.
- One sub-module: line_ram, single-port-read / single-port-write, parameterised depth and width, 1-cycle synchronous read. Instantiated twice (LA, LB).

Test Plan:
- Reset, then a 4-wide line, H_ACTIVE=4, pixels 0x0001..0x0004, row 0 → 2 cycles later data_valid_out=1 and line_out={0,0,0x0001}, then {0,0,0x0002}, and so on; vcount_out=0.
- Rows 0,1,2 with pixel value = row*16+col → at row 2 col 3: line_out[0]=0x0023, [1]=0x0013, [2]=0x0003. At row 1: [2]=0 and [1] is valid.
- New frame (vcount 0, hcount 0) after 3 rows → line_out[1] and [2] are 0 for all of row 0 despite stale memory contents.
- data_valid_in toggling 1-0-0-1 within a line → data_valid_out follows with 2-cycle delay; no memory write on idle cycles; columns stay aligned.
- hcount_in=H_ACTIVE+5 with valid=1 → data_valid_out=0, memories untouched, hcount_out=H_ACTIVE+5 two cycles later.
- rst_in asserted mid-row 2 → outputs 0 immediately (async); the next two full lines output masked rows.
